// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage: widths, halt encoding,
// FSM states and a saturating counter helper.
package cpu_pkg;
    localparam int PC_W      = 10;
    localparam int CNT_W     = 16;
    localparam int LUT_IDX_W = 4;
    localparam int LUT_DEPTH = 16;
    localparam logic [8:0] HALT_WORD = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction
endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Jump-target table: 16 absolute pc targets, one synchronous write port and a
// combinational read port, so a same-cycle write is seen by readers next cycle.
module jump_lut
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [LUT_IDX_W-1:0] wr_idx_i,
    input  pc_t                  wr_data_i,
    input  logic [LUT_IDX_W-1:0] rd_idx_i,
    output pc_t                  rd_data_o
);
    pc_t tab_q [LUT_DEPTH];

    // Table storage: cleared on reset, one entry updated per write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_q <= '{default: '0};
        end else if (wr_en_i) begin
            tab_q[wr_idx_i] <= wr_data_i;
        end else begin
            tab_q <= tab_q;
        end
    end

    assign rd_data_o = tab_q[rd_idx_i];
endmodule

// File: rtl/fetch_unit.sv
// Program counter, run/done FSM and executed-cycle counter; forwards ROM words
// to the decoder only while a program is running.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_W-1:0]      start_addr,
    output logic [PC_W-1:0]      instr_addr,
    input  logic [8:0]           instr_data,
    output logic [8:0]           instr,
    output logic                 instr_valid,
    input  logic                 pc_jmp_en,
    input  logic [LUT_IDX_W-1:0] lut_ptr,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_cnt
);
    fetch_state_t state_q;
    pc_t          pc_q;
    pc_t          pc_inc_d;
    pc_t          jmp_target_s;
    cnt_t         cnt_q;
    cnt_t         cnt_d;
    logic         done_q;
    logic         valid_q;
    logic         halt_s;

    jump_lut u_jump_lut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (lut_wr_en),
        .wr_idx_i  (lut_wr_idx),
        .wr_data_i (lut_wr_data),
        .rd_idx_i  (lut_ptr),
        .rd_data_o (jmp_target_s)
    );

    assign halt_s   = (instr_data == HALT_WORD);
    assign pc_inc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign cnt_d    = sat_inc(cnt_q);

    // Run/done FSM with pc, cycle counter and status flags as registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        pc_q    <= start_addr;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    // Halt wins over a jump decoded from the same word.
                    if (halt_s) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (pc_jmp_en) begin
                        pc_q <= jmp_target_s;
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign instr_addr  = pc_q;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? instr_data : 9'h000;
    assign done        = done_q;
    assign cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural ROM.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [9:0]  instr_addr;
    logic [8:0]  instr_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        pc_jmp_en;
    logic [3:0]  lut_ptr;
    logic        lut_wr_en;
    logic [3:0]  lut_wr_idx;
    logic [9:0]  lut_wr_data;
    logic        done;
    logic [15:0] cycle_cnt;

    logic [8:0] rom [1024];
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        st;
        logic [9:0]  saddr;
        logic        jmp;
        logic [3:0]  ptr;
        logic        wr;
        logic [3:0]  widx;
        logic [9:0]  wdata;
        logic [9:0]  e_addr;
        logic        e_valid;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [27];

    always #5 clk = ~clk;
    assign instr_data = rom[instr_addr];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .instr_addr(instr_addr), .instr_data(instr_data), .instr(instr),
        .instr_valid(instr_valid), .pc_jmp_en(pc_jmp_en), .lut_ptr(lut_ptr),
        .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
        .done(done), .cycle_cnt(cycle_cnt)
    );

    function automatic vec_t v(input logic st, input int saddr, input logic jmp, input int ptr,
                               input logic wr, input int widx, input int wdata,
                               input int ea, input logic ev, input logic ed, input int ec);
        vec_t r;
        r.st = st; r.saddr = 10'(saddr); r.jmp = jmp; r.ptr = 4'(ptr);
        r.wr = wr; r.widx = 4'(widx); r.wdata = 10'(wdata);
        r.e_addr = 10'(ea); r.e_valid = ev; r.e_done = ed; r.e_cnt = 16'(ec);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int ea, input logic ev, input logic ed, input int ec);
        chk({tag, " instr_addr"}, int'(instr_addr), ea);
        chk({tag, " instr_valid"}, int'(instr_valid), int'(ev));
        chk({tag, " done"}, int'(done), int'(ed));
        chk({tag, " cycle_cnt"}, int'(cycle_cnt), ec);
        chk({tag, " instr"}, int'(instr), ev ? int'(rom[ea[9:0]]) : 0);
    endtask

    task automatic drive_idle();
        start = 1'b0; start_addr = 10'd0; pc_jmp_en = 1'b0; lut_ptr = 4'd0;
        lut_wr_en = 1'b0; lut_wr_idx = 4'd0; lut_wr_data = 10'd0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i % 200);
        rom[3]  = 9'h1FF;
        rom[13] = 9'h1FF;
        rom[52] = 9'h1FF;

        //          st saddr jmp ptr wr widx wdata  addr  v  d  cnt
        vecs[0]  = v(1, 10,   0, 0,  0, 0, 0,      10,   1, 0, 0);
        vecs[1]  = v(0, 0,    0, 0,  0, 0, 0,      11,   1, 0, 1);
        vecs[2]  = v(0, 0,    0, 0,  0, 0, 0,      12,   1, 0, 2);
        vecs[3]  = v(0, 0,    0, 0,  0, 0, 0,      13,   1, 0, 3);
        vecs[4]  = v(0, 0,    0, 0,  0, 0, 0,      13,   0, 1, 4);
        vecs[5]  = v(0, 0,    0, 0,  0, 0, 0,      13,   0, 1, 4);
        vecs[6]  = v(0, 0,    0, 0,  1, 2, 40,     13,   0, 1, 4);
        vecs[7]  = v(1, 20,   0, 0,  0, 0, 0,      20,   1, 0, 0);
        vecs[8]  = v(0, 0,    1, 2,  0, 0, 0,      40,   1, 0, 1);
        vecs[9]  = v(0, 0,    0, 0,  0, 0, 0,      41,   1, 0, 2);
        vecs[10] = v(0, 0,    1, 2,  1, 2, 50,     40,   1, 0, 3);
        vecs[11] = v(0, 0,    1, 2,  0, 0, 0,      50,   1, 0, 4);
        vecs[12] = v(0, 0,    0, 0,  0, 0, 0,      51,   1, 0, 5);
        vecs[13] = v(0, 0,    0, 0,  0, 0, 0,      52,   1, 0, 6);
        vecs[14] = v(0, 0,    1, 2,  0, 0, 0,      52,   0, 1, 7);
        vecs[15] = v(1, 1023, 0, 0,  0, 0, 0,      1023, 1, 0, 0);
        vecs[16] = v(0, 0,    0, 0,  0, 0, 0,      0,    1, 0, 1);
        vecs[17] = v(1, 100,  0, 0,  0, 0, 0,      1,    1, 0, 2);
        vecs[18] = v(0, 0,    0, 0,  0, 0, 0,      2,    1, 0, 3);
        vecs[19] = v(0, 0,    0, 0,  0, 0, 0,      3,    1, 0, 4);
        vecs[20] = v(0, 0,    0, 0,  0, 0, 0,      3,    0, 1, 5);
        vecs[21] = v(1, 0,    0, 0,  0, 0, 0,      0,    1, 0, 0);
        vecs[22] = v(0, 0,    0, 0,  0, 0, 0,      1,    1, 0, 1);
        vecs[23] = v(0, 0,    0, 0,  0, 0, 0,      2,    1, 0, 2);
        vecs[24] = v(0, 0,    0, 0,  0, 0, 0,      3,    1, 0, 3);
        vecs[25] = v(0, 0,    0, 0,  0, 0, 0,      3,    0, 1, 4);
        vecs[26] = v(0, 0,    1, 2,  0, 0, 0,      3,    0, 1, 4);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            start = vecs[i].st; start_addr = vecs[i].saddr;
            pc_jmp_en = vecs[i].jmp; lut_ptr = vecs[i].ptr;
            lut_wr_en = vecs[i].wr; lut_wr_idx = vecs[i].widx; lut_wr_data = vecs[i].wdata;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].e_addr), vecs[i].e_valid,
                     vecs[i].e_done, int'(vecs[i].e_cnt));
        end

        // Asynchronous reset in the middle of a run must clear everything at once.
        @(negedge clk);
        drive_idle();
        lut_wr_en = 1'b1; lut_wr_idx = 4'd3; lut_wr_data = 10'd77;
        @(negedge clk);
        drive_idle();
        start = 1'b1; start_addr = 10'd4;
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        chk_outs("pre_reset", 5, 1'b1, 1'b0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_reset", 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; start_addr = 10'd200;
        @(posedge clk);
        #1;
        chk_outs("post_reset_start", 200, 1'b1, 1'b0, 0);
        @(negedge clk);
        drive_idle();
        pc_jmp_en = 1'b1; lut_ptr = 4'd3;
        @(posedge clk);
        #1;
        chk_outs("cleared_jtab3", 0, 1'b1, 1'b0, 1);
        @(negedge clk);
        drive_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
